// File: rtl/estacao_reserva_mem.sv
// In-order reservation station for the load/store unit: DEPTH-entry ring buffer, CDB snoop, head-only dispatch.
// Optional RS_MEM_CDB_BYPASS_EN: issuing ops capture a same-cycle CDB broadcast instead of stalling issue.
module estacao_reserva_mem #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Issue_valid,
    output logic                     Issue_ready,
    input  logic [2:0]               Issue_op,
    input  logic [15:0]              Issue_Vj,
    input  logic [15:0]              Issue_Vk,
    input  logic [TAG_W-1:0]         Issue_Qj,
    input  logic [TAG_W-1:0]         Issue_Qk,
    input  logic [TAG_W-1:0]         Issue_dest,
    input  logic                     CDB_valid,
    input  logic [TAG_W-1:0]         CDB_tag,
    input  logic [15:0]              CDB_data,
    input  logic                     Busy,
    input  logic                     Done,
    output logic                     Ready_to_uf,
    output logic [15:0]              A,
    output logic [15:0]              B,
    output logic [2:0]               Ufop,
    output logic [TAG_W-1:0]         Uf_tag,
    output logic                     Clear,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic             busy;
        logic [2:0]       op;
        logic [15:0]      vj;
        logic [15:0]      vk;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [TAG_W-1:0] dest;
    } rs_entry_t;

    typedef enum logic [1:0] {IDLE, EXEC, CLR} state_t;

    rs_entry_t        ent [DEPTH];
    logic [PW-1:0]    head, tail;
    state_t           state, state_nxt;
    logic             alloc, free, head_rdy;
    logic [15:0]      iss_vj, iss_vk;
    logic [TAG_W-1:0] iss_qj, iss_qk;

`ifdef RS_MEM_CDB_BYPASS_EN
    assign Issue_ready = Count < (PW+1)'(DEPTH);
`else
    // Stalling issue during a broadcast guarantees no tag is resolved while an op is in transit.
    assign Issue_ready = (Count < (PW+1)'(DEPTH)) && !CDB_valid;
`endif

    assign alloc    = Issue_valid && Issue_ready && (Issue_op == 3'd4 || Issue_op == 3'd5);
    assign free     = (state == CLR);
    assign head_rdy = ent[head].busy && (ent[head].qj == '0) && (ent[head].qk == '0) && !Busy;

    always_comb begin
        iss_vj = Issue_Vj;
        iss_vk = Issue_Vk;
        iss_qj = Issue_Qj;
        iss_qk = Issue_Qk;
`ifdef RS_MEM_CDB_BYPASS_EN
        if (CDB_valid && Issue_Qj != '0 && Issue_Qj == CDB_tag) begin
            iss_vj = CDB_data;
            iss_qj = '0;
        end
        if (CDB_valid && Issue_Qk != '0 && Issue_Qk == CDB_tag) begin
            iss_vk = CDB_data;
            iss_qk = '0;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (head_rdy) state_nxt = EXEC;
            EXEC:    if (Done)     state_nxt = CLR;
            CLR:                   state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head  <= '0;
            tail  <= '0;
            Count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent[i].busy && CDB_valid && ent[i].qj != '0 && ent[i].qj == CDB_tag) begin
                    ent[i].vj <= CDB_data;
                    ent[i].qj <= '0;
                end
                if (ent[i].busy && CDB_valid && ent[i].qk != '0 && ent[i].qk == CDB_tag) begin
                    ent[i].vk <= CDB_data;
                    ent[i].qk <= '0;
                end
            end
            // Tail slot is never busy while Count < DEPTH, so this cannot clobber a live entry.
            if (alloc) begin
                ent[tail] <= '{busy: 1'b1, op: Issue_op, vj: iss_vj, vk: iss_vk,
                               qj: iss_qj, qk: iss_qk, dest: Issue_dest};
                tail      <= tail + 1'b1;
            end
            if (free) begin
                ent[head].busy <= 1'b0;
                head           <= head + 1'b1;
            end
            case ({alloc, free})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            Ready_to_uf <= 1'b0;
            Clear       <= 1'b0;
            A           <= '0;
            B           <= '0;
            Ufop        <= '0;
            Uf_tag      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == EXEC) begin
                A           <= ent[head].vj;
                B           <= ent[head].vk;
                Ufop        <= ent[head].op;
                Uf_tag      <= ent[head].dest;
                Ready_to_uf <= 1'b1;
            end else if (state == EXEC && Done) begin
                Ready_to_uf <= 1'b0;
                Clear       <= 1'b1;
            end else if (state == CLR) begin
                Clear <= 1'b0;
            end
        end
    end
endmodule

// File: doc/estacao_reserva_mem.md
# estacao_reserva_mem

Reservation station for the memory (load/store) functional unit of the Tomasulo core. Accepts issued memory ops from the issue stage, holds them in a DEPTH-entry in-order buffer, captures missing operands by snooping the CDB, and drives the functional unit's `Ready_to_uf`/`A`/`B`/`Ufop`/`Clear` handshake. It is the requesting end of the functional-unit protocol, and frees each entry once the unit reports `Done`.

## Interface
- `DEPTH`, 4: entry count; power of two, minimum 2.
- `TAG_W`, 3: producer tag width; tag 0 means "value present".
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-high; sampled on the `Clock` rising edge.
- `Issue_valid`  in  1  issue request.
- `Issue_ready`  out  1  entry available; a transfer occurs when `Issue_valid` and `Issue_ready` are both 1.
- `Issue_op`  in  3  4 = load, 5 = store; any other value is accepted and discarded.
- `Issue_Vj`, `Issue_Vk`  in  16 each  operand values.
- `Issue_Qj`, `Issue_Qk`  in  TAG_W each  producer tags; 0 means the matching V is valid.
- `Issue_dest`  in  TAG_W  tag of this op's result.
- `CDB_valid`  in  1  broadcast strobe.
- `CDB_tag`  in  TAG_W  broadcast tag.
- `CDB_data`  in  16  broadcast value.
- `Busy`  in  1  functional unit occupied.
- `Done`  in  1  functional unit finished the current op.
- `Ready_to_uf`  out  1  op presented to the functional unit.
- `A`, `B`  out  16 each  operand j and operand k.
- `Ufop`  out  3  operation code.
- `Uf_tag`  out  TAG_W  dest tag of the op in flight, for the CDB arbiter.
- `Clear`  out  1  one-cycle functional-unit clear.
- `Count`  out  log2(DEPTH)+1  occupied entries.

## Operation
- Storage is a circular buffer with head, tail and count registers. Each entry holds busy, op, Vj, Vk, Qj, Qk, dest.
- Issue:
  - When the handshake completes with op 4 or 5, write the tail entry and increment tail, wrapping modulo DEPTH.
  - Other ops are consumed without allocating an entry.
  - `Issue_ready` = (Count < DEPTH), subject to the Configuration rule below.
- CDB snoop: every busy entry with Qj == `CDB_tag` (and Qj ≠ 0) loads Vj ← `CDB_data` and clears Qj to 0. Qk is handled the same way. All matching entries update in the same cycle.
- Dispatch is strictly in program order: only the head entry may dispatch, so memory ordering is preserved.
- FSM states:
  - IDLE → EXEC when the head is busy, its Qj == 0, its Qk == 0, and `Busy` == 0. On this transition, register `A`=Vj, `B`=Vk, `Ufop`=op, `Uf_tag`=dest, and set `Ready_to_uf`=1.
  - EXEC: `Ready_to_uf`, `A`, `B`, `Ufop` and `Uf_tag` are held stable. On `Done`=1, go to CLR with `Ready_to_uf`=0 and `Clear`=1.
  - CLR: lasts one cycle. `Clear` returns to 0, the head entry is freed, head increments, and the FSM returns to IDLE.
- When issue and free occur in the same cycle, Count is unchanged.
- `Done` is ignored outside EXEC.

## Timing
- Issue-to-dispatch latency with both operands ready: issue accepted at edge N, `Ready_to_uf`=1 after edge N+1.
- CDB capture takes effect at the broadcast edge, so the entry can dispatch after the following edge.
- Entry-free timing: `Done` seen at edge M, `Clear`=1 during M..M+1, entry freed at edge M+1, `Issue_ready` reflects the freed slot after M+1.
- Full buffer: `Issue_ready`=0, and no entry is overwritten.
- Empty buffer: the FSM stays in IDLE with `Ready_to_uf`=0.
- Reset, including mid-EXEC: clears all busy bits, head, tail, Count and FSM (→ IDLE). Reset value of every output is 0: `Ready_to_uf`, `A`, `B`, `Ufop`, `Uf_tag`, `Clear` and `Count`. `Issue_ready` is 1 after the first reset edge.

## Configuration
- `RS_MEM_CDB_BYPASS_EN` defined:
  - If an issuing op has Qj or Qk equal to `CDB_tag` while `CDB_valid`=1 in the same cycle, the entry is written with `CDB_data` and the tag is cleared.
  - `Issue_ready` does not depend on the CDB.
- Undefined: `Issue_ready` is also forced to 0 in any cycle with `CDB_valid`=1, so no broadcast can be missed.

## Test plan
- Reset, then issue a load with Vj=0x0003, Vk=0x0002, Qj=Qk=0, dest=1 → `Ready_to_uf`=1 with A=3, B=2, Ufop=4, Uf_tag=1. Drive `Done` → one `Clear` pulse, and Count returns to 0.
- Issue a store with Qj=2; drive CDB tag=2, data=0x00AA two cycles later → dispatch on the next cycle with A=0x00AA. No dispatch occurs before the broadcast.
- Issue 4 loads with `Done` held low → `Issue_ready`=0 and Count=4. A 5th issue is refused. After one `Done`, Count=3 and `Issue_ready`=1.
- Oldest op waiting on tag 3, younger op ready → no dispatch until tag 3 is broadcast, then ops dispatch in issue order.
- Issue with Qk=5 in the same cycle as CDB tag 5, data 0x1234 → with the macro defined, B=0x1234 at dispatch. Without the macro, `Issue_ready`=0 that cycle.
- Assert `Reset` during EXEC → the next cycle has `Ready_to_uf`=0, Count=0, and FSM in IDLE. An issue with op=0 leaves Count=0.
